// File: rtl/serialize_3d_array.sv
// serialize_3d_array
//   Captures a ROWS x COLS frame of BIT_WIDTH-bit elements in one handshake.
//   Streams it out one element per accepted beat, in row-major order.
//   The captured frame stays stable until the next capture or reset.
//
//   Optional feature: define SERIALIZE_3D_ARRAY_INDEX_EN to add the out_row /
//   out_col ports. They carry the coordinates of the element on out_data.
//
//   in_ready, out_valid, out_last and busy come only from registered state.
//   out_data is a mux of the registered frame, indexed by the registered
//   counters.

module serialize_3d_array #(
    parameter int BIT_WIDTH = 4,
    parameter int ROWS      = 8,
    parameter int COLS      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] in [ROWS][COLS],
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] out_data,
    output logic                 out_last,
`ifdef SERIALIZE_3D_ARRAY_INDEX_EN
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row,
    output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0] out_col,
`endif
    output logic                 busy
);

    // Counter widths never drop below one bit, so a 1x1 frame still has legal counters
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [RW-1:0]        row_q;
    logic [CW-1:0]        col_q;
    logic [BIT_WIDTH-1:0] frame_q [ROWS][COLS];

    logic capture;
    logic accept;
    logic last;

    // The last element is the only one at both counter maxima
    assign last = (state_q == STREAM) && (row_q == ROW_MAX) && (col_q == COL_MAX);

    // State register; reset drops any partial frame
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and handshake decode, with outputs derived only from state
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        capture   = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    capture = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    accept = 1'b1;
                    if (last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Row-major position counters; they wrap to [0][0] after the last beat
    always_ff @(posedge clk) begin
        if (rst || capture) begin
            row_q <= '0;
            col_q <= '0;
        end else if (accept) begin
            if (last) begin
                row_q <= '0;
                col_q <= '0;
            end else if (col_q == COL_MAX) begin
                col_q <= '0;
                row_q <= row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    // Frame buffer; it is written only on capture, so upstream may change freely mid-stream
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    frame_q[r][c] <= '0;
        end else if (capture) begin
            frame_q <= in;
        end
    end

    assign out_data = frame_q[row_q][col_q];
    assign out_last = last;

`ifdef SERIALIZE_3D_ARRAY_INDEX_EN
    assign out_row = row_q;
    assign out_col = col_q;
`endif

endmodule
